mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/arb_rr2.sv | 36 +++
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory arbiter.
//   LINE_W        : default cacheline width in bits
//   LINE_OFFSET_W : byte-offset bits inside a line (cleared on the pmem address)
//   arb_state_t   : arbiter FSM states
//   GRANT_I/D     : encoding of the last_grant flag
package pipeline_pkg;

  localparam int LINE_W        = 256;
  localparam int LINE_OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker (purely combinational).
// Ports:
//   req_i, req_d : pending requests from the I and D sides
//   last_grant   : side that won the previous grant (GRANT_I / GRANT_D)
//   gnt_i, gnt_d : one-hot winner, both 0 when nothing is pending
module arb_rr2
  import pipeline_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_i,
  output logic gnt_d
);

  // Single winner; on a tie the side that did not win last time goes first.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (req_i && req_d) begin
      if (last_grant == GRANT_D) begin
        gnt_i = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else if (req_i) begin
      gnt_i = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache line fills and D-cache fills/writebacks onto one
// physical memory port. A request is latched at grant time, so the
// requester may change its inputs freely while the transfer is running.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   imem_read, imem_address        : I-side fill request
//   imem_rdata, imem_resp          : I-side returned line / completion pulse
//   dmem_read, dmem_write          : D-side fill / writeback request
//   dmem_address, dmem_wdata       : D-side line address / writeback data
//   dmem_rdata, dmem_resp          : D-side returned line / completion pulse
//   pmem_read, pmem_write          : physical memory command
//   pmem_address, pmem_wdata       : physical line address / write data
//   pmem_rdata, pmem_resp          : physical returned line / completion
module mem_arbiter #(
  parameter int LINE_W = pipeline_pkg::LINE_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

  arb_state_t        state_q,      state_d;
  logic              last_grant_q, last_grant_d;
  logic              is_write_q,   is_write_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [LINE_W-1:0] wdata_q,      wdata_d;
  logic [LINE_W-1:0] irdata_q,     irdata_d;
  logic [LINE_W-1:0] drdata_q,     drdata_d;
  logic              pmem_read_q,  pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic              iresp_q,      iresp_d;
  logic              dresp_q,      dresp_d;

  logic gnt_i_s;
  logic gnt_d_s;

  arb_rr2 u_rr (
    .req_i      (imem_read),
    .req_d      (dmem_read | dmem_write),
    .last_grant (last_grant_q),
    .gnt_i      (gnt_i_s),
    .gnt_d      (gnt_d_s)
  );

  // Next-state, request latching and registered output values.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    iresp_d      = 1'b0;
    dresp_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_i_s) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
          is_write_d   = 1'b0;
          addr_d       = imem_address & LINE_MASK;
          wdata_d      = dmem_wdata;
          pmem_read_d  = 1'b1;
          pmem_write_d = 1'b0;
        end else if (gnt_d_s) begin
          // A simultaneous read+write is taken as a writeback only.
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          is_write_d   = dmem_write;
          addr_d       = dmem_address & LINE_MASK;
          wdata_d      = dmem_wdata;
          pmem_read_d  = ~dmem_write;
          pmem_write_d = dmem_write;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = RESP_I;
          irdata_d     = pmem_rdata;
          iresp_d      = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = RESP_D;
          dresp_d      = 1'b1;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          if (!is_write_q) begin
            drdata_d = pmem_rdata;
          end else begin
            drdata_d = drdata_q;
          end
        end else begin
          state_d = SERVE_D;
        end
      end
      RESP_I, RESP_D: begin
        // Requests seen here are left for the next IDLE cycle.
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        pmem_read_d  = 1'b0;
        pmem_write_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      iresp_q      <= 1'b0;
      dresp_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      iresp_q      <= iresp_d;
      dresp_q      <= dresp_d;
    end
  end

  assign imem_rdata   = irdata_q;
  assign imem_resp    = iresp_q;
  assign dmem_rdata   = drdata_q;
  assign dmem_resp    = dresp_q;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table, directed corner
// sequences and random traffic, all compared against a transaction-level
// reference model.
module tb_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_read;
  logic [ADDR_W-1:0] imem_address;
  logic [LINE_W-1:0] imem_rdata;
  logic              imem_resp;
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [LINE_W-1:0] dmem_wdata;
  logic [LINE_W-1:0] dmem_rdata;
  logic              dmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checka(input string name, input logic [ADDR_W-1:0] act,
                        input logic [ADDR_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkw(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  // One outstanding transfer at most; after it completes there is a single
  // response cycle in which no new request is looked at.
  bit              m_busy;
  bit              m_cool;
  bit              m_side;     // 0 = I, 1 = D
  bit              m_wr;
  bit              m_last_d;   // last grant went to D
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_irdata;
  logic [LINE_W-1:0] m_drdata;

  task automatic model_reset();
    m_busy = 1'b0; m_cool = 1'b0; m_side = 1'b0; m_wr = 1'b0;
    m_last_d = 1'b1;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic model_edge();
    bit want_i, want_d, pick_d;
    if (m_cool) begin
      m_cool = 1'b0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        if (!m_wr) begin
          if (m_side) m_drdata = pmem_rdata;
          else        m_irdata = pmem_rdata;
        end
        m_busy = 1'b0;
        m_cool = 1'b1;
      end
    end else begin
      want_i = imem_read;
      want_d = dmem_read | dmem_write;
      if (want_i || want_d) begin
        pick_d   = want_d && (!want_i || !m_last_d);
        m_side   = pick_d;
        m_last_d = pick_d;
        m_busy   = 1'b1;
        m_wr     = pick_d && dmem_write;
        m_addr   = (pick_d ? dmem_address : imem_address) & 32'hFFFF_FFE0;
        m_wdata  = dmem_wdata;
      end
    end
  endtask

  task automatic compare_all();
    check1("pmem_read",  pmem_read,  m_busy && !m_wr);
    check1("pmem_write", pmem_write, m_busy && m_wr);
    check1("imem_resp",  imem_resp,  m_cool && !m_side);
    check1("dmem_resp",  dmem_resp,  m_cool && m_side);
    checkw("imem_rdata", imem_rdata, m_irdata);
    checkw("dmem_rdata", dmem_rdata, m_drdata);
    if (m_busy) begin
      checka("pmem_address", pmem_address, m_addr);
      if (m_wr) checkw("pmem_wdata", pmem_wdata, m_wdata);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; pmem_resp = 1'b0;
    imem_address = '0; dmem_address = '0; dmem_wdata = '0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    checka("rst_pmem_address", pmem_address, '0);
    checkw("rst_pmem_wdata", pmem_wdata, '0);
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic ir, dr, dw, pr;          // inputs
    logic ex_pr, ex_pw, ex_ir, ex_dr; // pmem_read, pmem_write, imem_resp, dmem_resp
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [LINE_W-1:0] line_a5;
    logic [LINE_W-1:0] line_w;

    rst = 1'b1;
    idle_inputs();

    // Cycle-by-cycle protocol table, starting from reset (last grant = D).
    tbl[0]  = 8'b1000_1000; // I only -> SERVE_I
    tbl[1]  = 8'b1000_1000; // waiting for pmem
    tbl[2]  = 8'b1001_0010; // pmem_resp -> imem_resp
    tbl[3]  = 8'b0100_0000; // D request during RESP_I not sampled
    tbl[4]  = 8'b0100_1000; // D read granted
    tbl[5]  = 8'b0101_0001; // dmem_resp
    tbl[6]  = 8'b1110_0000; // tie during RESP_D ignored
    tbl[7]  = 8'b1110_1000; // tie, last was D -> I read
    tbl[8]  = 8'b1111_0010; // imem_resp
    tbl[9]  = 8'b1110_0000; // back in IDLE
    tbl[10] = 8'b1110_0100; // tie, last was I -> D, write wins over read
    tbl[11] = 8'b0011_0001; // dmem_resp
    tbl[12] = 8'b0001_0000; // pmem_resp in IDLE ignored
    tbl[13] = 8'b0001_0000;

    do_reset();
    imem_address = 32'h0000_2040;
    dmem_address = 32'h0000_3063;
    for (int k = 0; k < 14; k++) begin
      imem_read  = tbl[k].ir;
      dmem_read  = tbl[k].dr;
      dmem_write = tbl[k].dw;
      pmem_resp  = tbl[k].pr;
      pmem_rdata = rand_line();
      dmem_wdata = rand_line();
      step();
      check1($sformatf("tbl%0d_pmem_read", k),  pmem_read,  tbl[k].ex_pr);
      check1($sformatf("tbl%0d_pmem_write", k), pmem_write, tbl[k].ex_pw);
      check1($sformatf("tbl%0d_imem_resp", k),  imem_resp,  tbl[k].ex_ir);
      check1($sformatf("tbl%0d_dmem_resp", k),  dmem_resp,  tbl[k].ex_dr);
    end

    // I-only read, memory answers after three cycles.
    do_reset();
    line_a5 = {(LINE_W/8){8'hA5}};
    imem_read = 1'b1; imem_address = 32'h0000_1004;
    step();
    checka("i_read_addr", pmem_address, 32'h0000_1000);
    step();
    step();
    pmem_resp = 1'b1; pmem_rdata = line_a5;
    step();
    check1("i_read_resp", imem_resp, 1'b1);
    checkw("i_read_data", imem_rdata, line_a5);
    check1("i_read_dresp", dmem_resp, 1'b0);
    pmem_resp = 1'b0; imem_read = 1'b0; pmem_rdata = '0;
    step();
    check1("i_read_resp_one_cycle", imem_resp, 1'b0);

    // Simultaneous reads after reset: I first, then D.
    do_reset();
    imem_read = 1'b1; imem_address = 32'h0000_0100;
    dmem_read = 1'b1; dmem_address = 32'h0000_0200;
    step();
    checka("tie_first_i", pmem_address, 32'h0000_0100);
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    step();
    check1("tie_i_resp", imem_resp, 1'b1);
    imem_read = 1'b0; pmem_resp = 1'b0;
    step();
    step();
    checka("tie_then_d", pmem_address, 32'h0000_0200);
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    step();
    check1("tie_d_resp", dmem_resp, 1'b1);
    dmem_read = 1'b0; pmem_resp = 1'b0;
    step();

    // Writeback whose requester changes address/data mid-transfer.
    do_reset();
    line_w = {(LINE_W/32){32'h1234_5678}};
    dmem_write = 1'b1; dmem_address = 32'h8000_0020; dmem_wdata = line_w;
    step();
    check1("wb_write", pmem_write, 1'b1);
    dmem_address = 32'hDEAD_BEEF; dmem_wdata = ~line_w;
    step();
    checka("wb_addr_held", pmem_address, 32'h8000_0020);
    checkw("wb_data_held", pmem_wdata, line_w);
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    step();
    check1("wb_resp", dmem_resp, 1'b1);
    checkw("wb_no_rdata", dmem_rdata, '0);
    dmem_write = 1'b0; pmem_resp = 1'b0;
    step();

    // Reset in the middle of a D fill.
    do_reset();
    dmem_read = 1'b1; dmem_address = 32'h0000_0040;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    check1("mid_rst_pmem_read", pmem_read, 1'b0);
    check1("mid_rst_dresp", dmem_resp, 1'b0);
    model_reset();
    compare_all();
    dmem_read = 1'b0; pmem_resp = 1'b1;
    step();
    rst = 1'b1;
    step();
    check1("idle_pmem_resp_ignored", dmem_resp, 1'b0);
    pmem_resp = 1'b0;

    // Back-to-back I requests with immediate memory response.
    do_reset();
    imem_read = 1'b1; imem_address = 32'h0000_0480; pmem_resp = 1'b1;
    step();
    check1("b2b_cmd", pmem_read, 1'b1);
    step();
    check1("b2b_resp_n2", imem_resp, 1'b1);
    step();
    check1("b2b_idle", pmem_read, 1'b0);
    step();
    check1("b2b_regrant", pmem_read, 1'b1);
    step();
    imem_read = 1'b0; pmem_resp = 1'b0;
    step();
    step();

    // Random traffic against the model, with occasional async resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      imem_read    = ($urandom_range(0, 99) < 45);
      dmem_read    = ($urandom_range(0, 99) < 35);
      dmem_write   = ($urandom_range(0, 99) < 25);
      imem_address = $urandom;
      dmem_address = $urandom;
      dmem_wdata   = rand_line();
      pmem_rdata   = rand_line();
      pmem_resp    = ($urandom_range(0, 99) < 40);
      step();
      if ($urandom_range(0, 249) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        rst = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
